conn_req_arbiter: RTL and testbench

CONN_REQ_ARBITER -- requirements
Module: conn_req_arbiter

---
 rtl/conn_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_conn_req_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conn_req_arbiter.sv
// Two-requester round-robin arbiter in front of the connection searcher: SETUP -> ISSUE -> DRAIN.
// Define CA_TIMEOUT_EN to bound the ISSUE and DRAIN waits by TIMEOUT_CYCLES.
module conn_req_arbiter #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         ca_clk,
    input  logic         ca_rst,
    input  logic         ca_req0,
    input  logic         ca_req1,
    input  logic [1:0]   ca_op0,
    input  logic [1:0]   ca_op1,
    input  logic [143:0] ca_tuple0,
    input  logic [143:0] ca_tuple1,
    input  logic [7:0]   ca_id_in0,
    input  logic [7:0]   ca_id_in1,
    output logic         ca_ack0,
    output logic         ca_ack1,
    output logic [7:0]   ca_id_out,
    output logic [7:0]   ca_err_out,
    output logic         ca_busy,
    output logic [1:0]   ca_rs_rq,
    output logic [7:0]   ca_rs_id_in,
    output logic [23:0]  ca_rs_mac_src,
    output logic [23:0]  ca_rs_mac_dst,
    output logic [31:0]  ca_rs_ip_src,
    output logic [31:0]  ca_rs_ip_dst,
    output logic [15:0]  ca_rs_port_src,
    output logic [15:0]  ca_rs_port_dst,
    input  logic         ca_rs_done,
    input  logic [7:0]   ca_rs_id_out,
    input  logic [7:0]   ca_rs_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [7:0] ERR_ILLEGAL = 8'h04;
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);

`ifdef CA_TIMEOUT_EN
    localparam logic [7:0] ERR_TIMEOUT  = 8'hFF;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    logic [1:0]   state;
    logic         last_served;
    logic         gnt;
    logic [1:0]   op_q;
    logic [7:0]   setup_cnt;

    logic         req0_v;
    logic         req1_v;
    logic         pick1;
    logic [1:0]   sel_op;
    logic [143:0] sel_tuple;
    logic [7:0]   sel_id;

    // A requester is still holding req during its own ack cycle; mask it so it is not re-granted.
    assign req0_v    = ca_req0 & ~ca_ack0;
    assign req1_v    = ca_req1 & ~ca_ack1;
    assign pick1     = req1_v & (~req0_v | ~last_served);
    assign sel_op    = pick1 ? ca_op1    : ca_op0;
    assign sel_tuple = pick1 ? ca_tuple1 : ca_tuple0;
    assign sel_id    = pick1 ? ca_id_in1 : ca_id_in0;

    assign ca_busy = (state != S_IDLE);

    always_ff @(posedge ca_clk) begin
        if (ca_rst) begin
            state          <= S_IDLE;
            last_served    <= 1'b1;
            gnt            <= 1'b0;
            op_q           <= 2'b00;
            setup_cnt      <= '0;
            ca_ack0        <= 1'b0;
            ca_ack1        <= 1'b0;
            ca_id_out      <= '0;
            ca_err_out     <= '0;
            ca_rs_rq       <= 2'b00;
            ca_rs_id_in    <= '0;
            ca_rs_mac_src  <= '0;
            ca_rs_mac_dst  <= '0;
            ca_rs_ip_src   <= '0;
            ca_rs_ip_dst   <= '0;
            ca_rs_port_src <= '0;
            ca_rs_port_dst <= '0;
`ifdef CA_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            ca_ack0 <= 1'b0;
            ca_ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0_v | req1_v) begin
                        last_served <= pick1;
                        gnt         <= pick1;
                        // Only 01 and 10 are legal, which is exactly odd parity of the op.
                        if (^sel_op) begin
                            op_q        <= sel_op;
                            ca_rs_id_in <= sel_id;
                            {ca_rs_mac_src, ca_rs_mac_dst, ca_rs_ip_src, ca_rs_ip_dst,
                             ca_rs_port_src, ca_rs_port_dst} <= sel_tuple;
                            setup_cnt   <= '0;
                            state       <= S_SETUP;
                        end else begin
                            ca_ack0    <= ~pick1;
                            ca_ack1    <= pick1;
                            ca_id_out  <= 8'h00;
                            ca_err_out <= ERR_ILLEGAL;
                        end
                    end
                end
                S_SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        ca_rs_rq <= op_q;
                        state    <= S_ISSUE;
`ifdef CA_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end else begin
                        setup_cnt <= setup_cnt + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (ca_rs_done) begin
                        ca_ack0    <= ~gnt;
                        ca_ack1    <= gnt;
                        ca_id_out  <= ca_rs_id_out;
                        ca_err_out <= ca_rs_error;
                        ca_rs_rq   <= 2'b00;
                        state      <= S_DRAIN;
`ifdef CA_TIMEOUT_EN
                        to_cnt     <= '0;
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        ca_ack0    <= ~gnt;
                        ca_ack1    <= gnt;
                        ca_id_out  <= 8'h00;
                        ca_err_out <= ERR_TIMEOUT;
                        ca_rs_rq   <= 2'b00;
                        state      <= S_DRAIN;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
`endif
                    end
                end
                S_DRAIN: begin
                    // A done level left high from the last transaction must not complete the next one.
                    if (!ca_rs_done) begin
                        state <= S_IDLE;
`ifdef CA_TIMEOUT_EN
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conn_req_arbiter.sv
// Self-checking bench for conn_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_conn_req_arbiter;

    localparam int SETUP = 2;
    localparam int TO    = 20;

    logic         clk = 1'b0;
    logic         rst;
    bit           r_req [2];
    logic [1:0]   r_op  [2];
    logic [143:0] r_tup [2];
    logic [7:0]   r_id  [2];
    logic         ca_ack0, ca_ack1, ca_busy;
    logic [7:0]   ca_id_out, ca_err_out, ca_rs_id_in;
    logic [1:0]   ca_rs_rq;
    logic [23:0]  ca_rs_mac_src, ca_rs_mac_dst;
    logic [31:0]  ca_rs_ip_src, ca_rs_ip_dst;
    logic [15:0]  ca_rs_port_src, ca_rs_port_dst;
    logic         done_s;
    logic [7:0]   rid_s, rerr_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: last-served requester and the result registers seen by requesters.
    bit         m_last = 1'b1;
    logic [7:0] m_id   = 8'h00;
    logic [7:0] m_err  = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conn_req_arbiter #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TO)) dut (
        .ca_clk(clk), .ca_rst(rst),
        .ca_req0(r_req[0]), .ca_req1(r_req[1]),
        .ca_op0(r_op[0]), .ca_op1(r_op[1]),
        .ca_tuple0(r_tup[0]), .ca_tuple1(r_tup[1]),
        .ca_id_in0(r_id[0]), .ca_id_in1(r_id[1]),
        .ca_ack0(ca_ack0), .ca_ack1(ca_ack1),
        .ca_id_out(ca_id_out), .ca_err_out(ca_err_out), .ca_busy(ca_busy),
        .ca_rs_rq(ca_rs_rq), .ca_rs_id_in(ca_rs_id_in),
        .ca_rs_mac_src(ca_rs_mac_src), .ca_rs_mac_dst(ca_rs_mac_dst),
        .ca_rs_ip_src(ca_rs_ip_src), .ca_rs_ip_dst(ca_rs_ip_dst),
        .ca_rs_port_src(ca_rs_port_src), .ca_rs_port_dst(ca_rs_port_dst),
        .ca_rs_done(done_s), .ca_rs_id_out(rid_s), .ca_rs_error(rerr_s)
    );

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rr_pick(input bit q0, input bit q1, input bit last);
        if (q0 && q1) return !last;
        return q1;
    endfunction

    function automatic bit legal(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    function automatic logic [1:0] ack_vec(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic request(input bit w, input logic [1:0] op);
        r_req[w] = 1'b1;
        r_op[w]  = op;
        r_tup[w] = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        r_id[w]  = 8'($urandom());
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            tick();
            chk("idle_busy", 144'(ca_busy), 144'(0));
            chk("idle_ack", 144'({ca_ack1, ca_ack0}), 144'(0));
            chk("hold_id", 144'(ca_id_out), 144'(m_id));
            chk("hold_err", 144'(ca_err_out), 144'(m_err));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        done_s = 1'b0;
        tick();
        chk("rst_ack", 144'({ca_ack1, ca_ack0}), 144'(0));
        chk("rst_busy", 144'(ca_busy), 144'(0));
        chk("rst_rq", 144'(ca_rs_rq), 144'(0));
        chk("rst_tuple", {ca_rs_mac_src, ca_rs_mac_dst, ca_rs_ip_src, ca_rs_ip_dst,
                          ca_rs_port_src, ca_rs_port_dst}, 144'(0));
        chk("rst_rs_id", 144'(ca_rs_id_in), 144'(0));
        chk("rst_id_out", 144'(ca_id_out), 144'(0));
        chk("rst_err_out", 144'(ca_err_out), 144'(0));
        rst = 1'b0;
        m_last = 1'b1;
        m_id = 8'h00;
        m_err = 8'h00;
    endtask

    // Serve the requester the model says wins now; the searcher answers after dly ISSUE cycles
    // and keeps done high for hold cycles after the ack.
    task automatic serve(input int dly, input int hold, input logic [7:0] rid, input logic [7:0] rerr);
        bit w;
        int c0;
        w = rr_pick(r_req[0], r_req[1], m_last);
        m_last = w;
        c0 = cyc;
        tick();
        if (!legal(r_op[w])) begin
            m_id = 8'h00;
            m_err = 8'h04;
            chk("ill_ack", 144'({ca_ack1, ca_ack0}), 144'(ack_vec(w)));
            chk("ill_err", 144'(ca_err_out), 144'(8'h04));
            chk("ill_id", 144'(ca_id_out), 144'(0));
            chk("ill_rq", 144'(ca_rs_rq), 144'(0));
            chk("ill_busy", 144'(ca_busy), 144'(0));
            if (!r_req[!w]) begin
                tick();
                chk("ill_once", 144'({ca_ack1, ca_ack0}), 144'(0));
                chk("ill_rq2", 144'(ca_rs_rq), 144'(0));
                chk("ill_busy2", 144'(ca_busy), 144'(0));
            end
            r_req[w] = 1'b0;
            return;
        end
        chk("grant_busy", 144'(ca_busy), 144'(1));
        chk("grant_tuple", {ca_rs_mac_src, ca_rs_mac_dst, ca_rs_ip_src, ca_rs_ip_dst,
                            ca_rs_port_src, ca_rs_port_dst}, r_tup[w]);
        chk("grant_rs_id", 144'(ca_rs_id_in), 144'(r_id[w]));
        for (int s = 0; s < SETUP; s++) begin
            if (s > 0) tick();
            chk("setup_rq", 144'(ca_rs_rq), 144'(0));
        end
        for (int k = 0; k <= dly; k++) begin
            tick();
            chk("issue_rq", 144'(ca_rs_rq), 144'(r_op[w]));
            chk("issue_noack", 144'({ca_ack1, ca_ack0}), 144'(0));
        end
        done_s = 1'b1;
        rid_s = rid;
        rerr_s = rerr;
        tick();
        m_id = rid;
        m_err = rerr;
        chk("ack", 144'({ca_ack1, ca_ack0}), 144'(ack_vec(w)));
        chk("ack_latency", 144'(cyc - c0), 144'(SETUP + 2 + dly));
        chk("id_out", 144'(ca_id_out), 144'(rid));
        chk("err_out", 144'(ca_err_out), 144'(rerr));
        chk("drain_rq", 144'(ca_rs_rq), 144'(0));
        r_req[w] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("drain_busy", 144'(ca_busy), 144'(1));
            chk("drain_noack", 144'({ca_ack1, ca_ack0}), 144'(0));
            chk("drain_rq_idle", 144'(ca_rs_rq), 144'(0));
        end
        done_s = 1'b0;
        rid_s = 8'($urandom());
        rerr_s = 8'($urandom());
        tick();
        chk("back_idle", 144'(ca_busy), 144'(0));
        chk("post_ack", 144'({ca_ack1, ca_ack0}), 144'(0));
    endtask

    initial begin
        logic [1:0] op;
        int pat;
        rst = 1'b1;
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        r_op[0] = 2'b00; r_op[1] = 2'b00;
        r_tup[0] = '0; r_tup[1] = '0;
        r_id[0] = '0; r_id[1] = '0;
        done_s = 1'b0; rid_s = '0; rerr_s = '0;
        tick();
        do_reset();
        idle_check(2);

        // Contention right after reset: requester 0 first, then 1.
        request(0, 2'b01);
        request(1, 2'b10);
        chk("contend_first", 144'(rr_pick(r_req[0], r_req[1], m_last)), 144'(0));
        serve(1, 0, 8'h11, 8'h00);
        serve(0, 1, 8'h22, 8'h01);
        idle_check(1);

        // Single open with a first-cycle answer.
        request(0, 2'b01);
        serve(0, 0, 8'h03, 8'h02);
        idle_check(2);

        // Stale done: winner keeps done high 5 cycles while the other requester waits.
        request(0, 2'b10);
        request(1, 2'b01);
        serve(0, 5, 8'h44, 8'h05);
        serve(2, 0, 8'h55, 8'h06);
        idle_check(1);

        // Illegal op from requester 1.
        request(1, 2'b11);
        serve(0, 0, 8'h00, 8'h00);
        idle_check(2);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            pat = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++) begin
                if (pat[r]) begin
                    if ($urandom_range(0, 5) == 0) op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                    else op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                    request(r[0], op);
                end
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom()), 8'($urandom()));
            if (r_req[0] || r_req[1])
                serve($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom()), 8'($urandom()));
            idle_check($urandom_range(1, 2));
        end

        // Searcher never answers.
        request(0, 2'b01);
        m_last = 1'b0;
        repeat (SETUP) tick();
`ifdef CA_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            tick();
            chk("to_issue_rq", 144'(ca_rs_rq), 144'(2'b01));
            chk("to_noack", 144'({ca_ack1, ca_ack0}), 144'(0));
        end
        tick();
        chk("to_ack", 144'({ca_ack1, ca_ack0}), 144'(2'b01));
        chk("to_err", 144'(ca_err_out), 144'(8'hFF));
        chk("to_id", 144'(ca_id_out), 144'(0));
        chk("to_rq", 144'(ca_rs_rq), 144'(0));
        r_req[0] = 1'b0;
        m_id = 8'h00;
        m_err = 8'hFF;
        done_s = 1'b1;
        for (int j = 1; j < TO; j++) begin
            tick();
            chk("to_drain_busy", 144'(ca_busy), 144'(1));
        end
        tick();
        chk("to_drain_exit", 144'(ca_busy), 144'(0));
        done_s = 1'b0;
        idle_check(2);
`else
        repeat (TO + 10) begin
            tick();
            chk("hang_noack", 144'({ca_ack1, ca_ack0}), 144'(0));
        end
        chk("hang_busy", 144'(ca_busy), 144'(1));
        do_reset();
        idle_check(1);
`endif

        // Reset in the third ISSUE cycle aborts without an ack.
        request(0, 2'b10);
        repeat (SETUP) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pre_rst_rq", 144'(ca_rs_rq), 144'(2'b10));
        end
        do_reset();
        idle_check(3);

        // Pointer is back to favouring requester 0.
        request(0, 2'b01);
        request(1, 2'b01);
        serve(0, 0, 8'h66, 8'h07);
        serve(0, 0, 8'h77, 8'h08);
        idle_check(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
